// File: rtl/dtcm_arbiter.sv
// rtl/dtcm_arbiter.sv - D-TCM two-port arbiter with read-modify-write sequencing for partial writes
// Optional round-robin arbitration: DTCM_ARB_RR_EN
module dtcm_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_we,
    input  logic [BE_WIDTH-1:0]   core_req_be,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_valid,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    input  logic                  dma_req_valid,
    output logic                  dma_req_ready,
    input  logic                  dma_req_we,
    input  logic [BE_WIDTH-1:0]   dma_req_be,
    input  logic [ADDR_WIDTH-1:0] dma_req_addr,
    input  logic [DATA_WIDTH-1:0] dma_req_wdata,
    output logic                  dma_rsp_valid,
    output logic [DATA_WIDTH-1:0] dma_rsp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {IDLE, RMW} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
    logic [BE_WIDTH-1:0]   rmw_be_q, rmw_be_d;
    logic [DATA_WIDTH-1:0] rmw_wdata_q, rmw_wdata_d;
    logic                  rmw_owner_q, rmw_owner_d;   // 1 = dma
    logic                  rsp_core_q, rsp_core_d;
    logic                  rsp_dma_q, rsp_dma_d;
    logic                  rsp_read_q, rsp_read_d;

    logic                  grant_core, grant_dma, accept;
    logic                  sel_we;
    logic [BE_WIDTH-1:0]   sel_be;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_full, sel_empty;
    logic [DATA_WIDTH-1:0] merged;

`ifdef DTCM_ARB_RR_EN
    logic prio_dma_q, prio_dma_d;

    always_comb begin
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (core_req_valid && dma_req_valid) begin
                grant_dma  = prio_dma_q;
                grant_core = !prio_dma_q;
            end else begin
                grant_core = core_req_valid;
                grant_dma  = dma_req_valid;
            end
        end
        prio_dma_d = accept ? grant_core : prio_dma_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) prio_dma_q <= 1'b0;
        else        prio_dma_q <= prio_dma_d;
    end
`else
    always_comb begin
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        if (rst_n && state_q == IDLE) begin
            grant_core = core_req_valid;
            grant_dma  = dma_req_valid && !core_req_valid;
        end
    end
`endif

    assign accept         = grant_core || grant_dma;
    assign core_req_ready = grant_core;
    assign dma_req_ready  = grant_dma;

    assign sel_we    = grant_dma ? dma_req_we    : core_req_we;
    assign sel_be    = grant_dma ? dma_req_be    : core_req_be;
    assign sel_addr  = grant_dma ? dma_req_addr  : core_req_addr;
    assign sel_wdata = grant_dma ? dma_req_wdata : core_req_wdata;
    assign sel_full  = &sel_be;
    assign sel_empty = (sel_be == '0);

    always_comb begin
        merged = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            merged[8*i +: 8] = rmw_be_q[i] ? rmw_wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_be_d    = rmw_be_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_owner_d = rmw_owner_q;
        rsp_core_d  = 1'b0;
        rsp_dma_d   = 1'b0;
        rsp_read_d  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr = sel_addr;
                    if (sel_we && !sel_full && !sel_empty) begin
                        // Partial write: this cycle reads the old word, next cycle writes the merge
                        rmw_addr_d  = sel_addr;
                        rmw_be_d    = sel_be;
                        rmw_wdata_d = sel_wdata;
                        rmw_owner_d = grant_dma;
                        state_d     = RMW;
                    end else begin
                        mem_we     = sel_we && sel_full;
                        mem_wdata  = (sel_we && sel_full) ? sel_wdata : '0;
                        rsp_core_d = grant_core;
                        rsp_dma_d  = grant_dma;
                        rsp_read_d = !sel_we;
                    end
                end
            end
            RMW: begin
                if (rst_n) begin
                    mem_we     = 1'b1;
                    mem_addr   = rmw_addr_q;
                    mem_wdata  = merged;
                    rsp_core_d = !rmw_owner_q;
                    rsp_dma_d  = rmw_owner_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rmw_addr_q  <= '0;
            rmw_be_q    <= '0;
            rmw_wdata_q <= '0;
            rmw_owner_q <= 1'b0;
            rsp_core_q  <= 1'b0;
            rsp_dma_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_be_q    <= rmw_be_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_owner_q <= rmw_owner_d;
            rsp_core_q  <= rsp_core_d;
            rsp_dma_q   <= rsp_dma_d;
            rsp_read_q  <= rsp_read_d;
        end
    end

    assign core_rsp_valid = rst_n && rsp_core_q;
    assign dma_rsp_valid  = rst_n && rsp_dma_q;
    assign core_rsp_rdata = (core_rsp_valid && rsp_read_q) ? mem_rdata : '0;
    assign dma_rsp_rdata  = (dma_rsp_valid && rsp_read_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// tb/tb_dtcm_arbiter.sv - directed self-checking bench for dtcm_arbiter with a behavioural D-TCM
module tb_dtcm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_valid, core_req_ready, core_req_we;
    logic [3:0]  core_req_be;
    logic [9:0]  core_req_addr;
    logic [31:0] core_req_wdata;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic        dma_req_valid, dma_req_ready, dma_req_we;
    logic [3:0]  dma_req_be;
    logic [9:0]  dma_req_addr;
    logic [31:0] dma_req_wdata;
    logic        dma_rsp_valid;
    logic [31:0] dma_rsp_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_core;

    dtcm_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_we    (core_req_we),
        .core_req_be    (core_req_be),
        .core_req_addr  (core_req_addr),
        .core_req_wdata (core_req_wdata),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_rdata (core_rsp_rdata),
        .dma_req_valid  (dma_req_valid),
        .dma_req_ready  (dma_req_ready),
        .dma_req_we     (dma_req_we),
        .dma_req_be     (dma_req_be),
        .dma_req_addr   (dma_req_addr),
        .dma_req_wdata  (dma_req_wdata),
        .dma_rsp_valid  (dma_rsp_valid),
        .dma_rsp_rdata  (dma_rsp_rdata),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h005] = 32'hDEADBEEF;
        mem[10'h010] = 32'h12345678;
        mem[10'h020] = 32'h11111111;
        mem_rdata = 32'h0;

        rst_n = 1'b0;
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_be = 4'h0;
        core_req_addr = 10'h005; core_req_wdata = 32'h0;
        dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_be = 4'h0;
        dma_req_addr = 10'h000; dma_req_wdata = 32'h0;

        // Reset: outputs held at zero even with a valid request present
        @(negedge clk); #1;
        chk("rst_core_ready", core_req_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_core_rsp", core_rsp_valid, 0);
        chk("rst_dma_rsp", dma_rsp_valid, 0);

        // Core read of 0x005
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rd_core_ready", core_req_ready, 1);
        chk("rd_dma_ready", dma_req_ready, 0);
        chk("rd_mem_addr", mem_addr, 10'h005);
        chk("rd_mem_we", mem_we, 0);
        @(negedge clk); core_req_valid = 1'b0; #1;
        chk("rd_core_rsp", core_rsp_valid, 1);
        chk("rd_core_rdata", core_rsp_rdata, 32'hDEADBEEF);
        chk("rd_dma_rsp", dma_rsp_valid, 0);
        chk("idle_mem_addr", mem_addr, 0);

        // DMA partial write -> RMW, core read of the same word queued behind it
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_be = 4'b0011;
        dma_req_addr = 10'h010; dma_req_wdata = 32'h0000AAAA;
        #1;
        chk("pw_dma_ready", dma_req_ready, 1);
        chk("pw_read_we", mem_we, 0);
        chk("pw_read_addr", mem_addr, 10'h010);
        @(negedge clk);
        dma_req_valid = 1'b0;
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 10'h010;
        #1;
        chk("rmw_core_ready", core_req_ready, 0);
        chk("rmw_dma_ready", dma_req_ready, 0);
        chk("rmw_mem_we", mem_we, 1);
        chk("rmw_mem_addr", mem_addr, 10'h010);
        chk("rmw_mem_wdata", mem_wdata, 32'h1234AAAA);
        chk("rmw_dma_rsp_early", dma_rsp_valid, 0);
        @(negedge clk); #1;
        chk("pw_dma_rsp", dma_rsp_valid, 1);
        chk("pw_dma_rdata", dma_rsp_rdata, 0);
        chk("raw_core_ready", core_req_ready, 1);
        chk("raw_core_rsp_idle", core_rsp_valid, 0);
        @(negedge clk); core_req_valid = 1'b0; #1;
        chk("raw_core_rsp", core_rsp_valid, 1);
        chk("raw_core_rdata", core_rsp_rdata, 32'h1234AAAA);

        // Contention: both request reads for four cycles after a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 10'h005;
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 10'h010;
`ifdef DTCM_ARB_RR_EN
        exp_core = 4'b0101;
`else
        exp_core = 4'b1111;
`endif
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("arb_core_ready", core_req_ready, exp_core[k]);
            chk("arb_dma_ready", dma_req_ready, !exp_core[k]);
            if (k > 0) begin
                chk("arb_core_rsp", core_rsp_valid, exp_core[k-1]);
                chk("arb_dma_rsp", dma_rsp_valid, !exp_core[k-1]);
            end
        end
        @(negedge clk); core_req_valid = 1'b0; #1;
        chk("arb_dma_served", dma_req_ready, 1);
        chk("arb_core_rsp_last", core_rsp_valid, exp_core[3]);
        @(negedge clk); dma_req_valid = 1'b0; #1;
        chk("arb_dma_rsp_final", dma_rsp_valid, 1);
        chk("arb_dma_rdata", dma_rsp_rdata, 32'h1234AAAA);

        // Full write to the top address, read back-to-back
        core_req_valid = 1'b1; core_req_we = 1'b1; core_req_be = 4'hF;
        core_req_addr = 10'h3FF; core_req_wdata = 32'hCAFEF00D;
        #1;
        chk("fw_ready", core_req_ready, 1);
        chk("fw_mem_we", mem_we, 1);
        chk("fw_mem_addr", mem_addr, 10'h3FF);
        chk("fw_mem_wdata", mem_wdata, 32'hCAFEF00D);
        @(negedge clk); core_req_we = 1'b0; #1;
        chk("fw_rsp", core_rsp_valid, 1);
        chk("fw_rsp_rdata", core_rsp_rdata, 0);
        chk("fw_rd_ready", core_req_ready, 1);
        @(negedge clk); core_req_valid = 1'b0; #1;
        chk("fw_rd_rsp", core_rsp_valid, 1);
        chk("fw_rd_rdata", core_rsp_rdata, 32'hCAFEF00D);

        // Empty write leaves memory untouched
        core_req_valid = 1'b1; core_req_we = 1'b1; core_req_be = 4'h0;
        core_req_addr = 10'h005; core_req_wdata = 32'hFFFFFFFF;
        #1;
        chk("ew_ready", core_req_ready, 1);
        chk("ew_mem_we", mem_we, 0);
        @(negedge clk); core_req_we = 1'b0; #1;
        chk("ew_rsp", core_rsp_valid, 1);
        chk("ew_rsp_rdata", core_rsp_rdata, 0);
        @(negedge clk); core_req_valid = 1'b0; #1;
        chk("ew_rd_rdata", core_rsp_rdata, 32'hDEADBEEF);

        // Partial write abandoned by reset in its RMW cycle
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_be = 4'b1000;
        dma_req_addr = 10'h020; dma_req_wdata = 32'hAA000000;
        #1;
        chk("ab_dma_ready", dma_req_ready, 1);
        @(negedge clk); rst_n = 1'b0; dma_req_valid = 1'b0; #1;
        chk("ab_mem_we", mem_we, 0);
        chk("ab_mem_addr", mem_addr, 0);
        chk("ab_mem_wdata", mem_wdata, 0);
        chk("ab_dma_rsp", dma_rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 10'h020;
        #1;
        chk("ab_post_mem_we", mem_we, 0);
        chk("ab_post_dma_rsp", dma_rsp_valid, 0);
        chk("ab_post_ready", core_req_ready, 1);
        @(negedge clk); core_req_valid = 1'b0; #1;
        chk("ab_post_rsp", core_rsp_valid, 1);
        chk("ab_post_rdata", core_rsp_rdata, 32'h11111111);
        chk("ab_post_dma_rsp2", dma_rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
